// File: rtl/la_cmd_sequencer.sv
// LA-bus command sequencer: prescaled 32-bit match counter plus a 16-bit status word on mprj_io.
// Optional command parity checking is enabled by defining LA_CMD_PARITY_EN.
module la_cmd_sequencer #(
  parameter int COUNT_W   = 32,
  parameter int STAT_BASE = 16,
  parameter int PRESC_W   = 8
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [63:0] la_data_in,
  input  logic [63:0] la_oenb,
  output logic [63:0] la_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic [2:0]  irq
);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_MATCH = 2'b10} state_t;

  typedef struct packed {
    logic [7:0]         opcode;
    logic [1:0]         rsvd_hi;
    logic               par;
    logic [3:0]         rsvd_mid;
    logic               req;
    logic [15:0]        rsvd_lo;
    logic [COUNT_W-1:0] payload;
  } cmd_t;

  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_START  = 8'h02;
  localparam logic [7:0] OP_STOP   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] OP_CMP    = 8'h05;
  localparam logic [7:0] OP_PRESC  = 8'h06;
  localparam logic [7:0] OP_CLR    = 8'h07;

  state_t             state;
  logic [COUNT_W-1:0] count, compare;
  logic [PRESC_W-1:0] presc, pc;
  logic [15:0]        status;
  logic               status_en, match_sticky, err, ack, req_q, irq0, armed;
  cmd_t               cmd;
  logic               accept, hit;
  logic               unused_rsvd;

  assign cmd    = la_data_in & ~la_oenb;
  assign accept = cmd.req != req_q;
  // armed drops on a match so a resumed RUN at count == compare does not re-fire at once.
  assign hit    = (state == S_RUN) && (count == compare) && armed;

`ifdef LA_CMD_PARITY_EN
  logic par_err, cmd_ok;
  assign cmd_ok      = cmd.par == ^{cmd.opcode, cmd.payload};
  assign unused_rsvd = ^{cmd.rsvd_hi, cmd.rsvd_mid, cmd.rsvd_lo};
`else
  assign unused_rsvd = ^{cmd.rsvd_hi, cmd.par, cmd.rsvd_mid, cmd.rsvd_lo};
`endif

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state        <= S_IDLE;
      count        <= '0;
      compare      <= '1;
      presc        <= '0;
      pc           <= '0;
      status       <= '0;
      status_en    <= 1'b0;
      match_sticky <= 1'b0;
      err          <= 1'b0;
      ack          <= 1'b0;
      req_q        <= 1'b0;
      irq0         <= 1'b0;
      armed        <= 1'b1;
`ifdef LA_CMD_PARITY_EN
      par_err      <= 1'b0;
`endif
    end else begin
      irq0 <= 1'b0;
      // The counter freezes on a hit even when a command suppresses the match itself.
      if (state == S_RUN && !hit) begin
        if (pc == presc) begin
          pc    <= '0;
          count <= count + 1'b1;
          armed <= 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
      if (hit && !accept) begin
        state        <= S_MATCH;
        match_sticky <= 1'b1;
        irq0         <= 1'b1;
        status       <= status + 1'b1;
        armed        <= 1'b0;
      end
      if (accept) begin
        req_q <= cmd.req;
        ack   <= cmd.req;
`ifdef LA_CMD_PARITY_EN
        if (!cmd_ok) begin
          err     <= 1'b1;
          par_err <= 1'b1;
        end else
`endif
        case (cmd.opcode)
          OP_LOAD: begin
            count <= cmd.payload;
            armed <= 1'b1;
          end
          OP_START:  state <= S_RUN;
          OP_STOP:   state <= S_IDLE;
          OP_STATUS: begin
            status    <= cmd.payload[15:0];
            status_en <= 1'b1;
          end
          OP_CMP:    compare <= cmd.payload;
          OP_PRESC: begin
            presc <= cmd.payload[PRESC_W-1:0];
            pc    <= '0;
          end
          OP_CLR: begin
            match_sticky <= 1'b0;
            err          <= 1'b0;
`ifdef LA_CMD_PARITY_EN
            par_err      <= 1'b0;
`endif
          end
          default:   err <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[STAT_BASE +: 16] = status;
    io_oeb[STAT_BASE +: 16] = {16{~status_en}};
    la_data_out = '0;
    la_data_out[COUNT_W-1:0] = count;
    la_data_out[47:32] = status;
    la_data_out[48]    = ack;
    la_data_out[50:49] = state;
    la_data_out[51]    = match_sticky;
    la_data_out[52]    = err;
`ifdef LA_CMD_PARITY_EN
    la_data_out[53]    = par_err;
`endif
  end

  assign irq = {2'b00, irq0};

endmodule
